// File: rtl/reg_pchs_if.sv
// rtl/reg_pchs_if.sv - Load/data/increment bundle between the PC-high select register and its sequencer.
interface reg_pchs_if #(
    parameter int WIDTH = 8
);
    logic             PCH_LOAD;
    logic             ADH_LOAD;
    logic [WIDTH-1:0] PCH_DATA;
    logic [WIDTH-1:0] ADH_DATA;
    logic             INC;
    logic             CARRY_IN;
    logic             CARRY_OUT;
    logic [WIDTH-1:0] OUT;

    modport master (
        output PCH_LOAD, ADH_LOAD, PCH_DATA, ADH_DATA, INC, CARRY_IN,
        input  CARRY_OUT, OUT
    );

    modport slave (
        input  PCH_LOAD, ADH_LOAD, PCH_DATA, ADH_DATA, INC, CARRY_IN,
        output CARRY_OUT, OUT
    );
endinterface

// File: rtl/reg_pchs.sv
// rtl/reg_pchs.sv - 6502 PC-high select register; PCHS_INC_EN enables the internal page incrementer.
module reg_pchs #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic        CLK,
    input  logic        RST_N,
    reg_pchs_if.slave   bus
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;

    // ADH bus beats the PCH feedback path when both strobes fire together.
    always_comb begin
        out_d = out_q;
        if (bus.ADH_LOAD) begin
            out_d = bus.ADH_DATA;
        end else if (bus.PCH_LOAD) begin
            out_d = bus.PCH_DATA;
        end
`ifdef PCHS_INC_EN
        else if (bus.INC && bus.CARRY_IN) begin
            out_d = out_q + WIDTH'(1);
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_q <= RESET_VALUE;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.OUT = out_q;

`ifdef PCHS_INC_EN
    // Page-wrap carry for the 16-bit PC; forced low while reset is held.
    assign bus.CARRY_OUT = RST_N & bus.INC & bus.CARRY_IN & (&out_q);
`else
    logic unused_inc;
    assign unused_inc    = bus.INC ^ bus.CARRY_IN;
    assign bus.CARRY_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_reg_pchs.sv
// tb/tb_reg_pchs.sv - Directed and random checks of reg_pchs against a behavioural model.
module tb_reg_pchs;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   exp_out;

`ifdef PCHS_INC_EN
    localparam bit INC_EN = 1'b1;
`else
    localparam bit INC_EN = 1'b0;
`endif

    reg_pchs_if #(.WIDTH(8)) bus ();

    reg_pchs #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int model_next(input int cur);
        if (bus.ADH_LOAD === 1'b1) return int'(bus.ADH_DATA);
        if (bus.PCH_LOAD === 1'b1) return int'(bus.PCH_DATA);
        if (INC_EN && bus.INC === 1'b1 && bus.CARRY_IN === 1'b1) return (cur + 1) % 256;
        return cur;
    endfunction

    function automatic logic model_carry(input int cur);
        return INC_EN && rst_n && bus.INC === 1'b1 && bus.CARRY_IN === 1'b1 && cur == 255;
    endfunction

    task automatic step(input string tag);
        int nxt;
        nxt = model_next(exp_out);
        @(posedge clk);
        exp_out = nxt;
        #1;
        check(tag, bus.OUT, 8'(exp_out));
        check({tag, "_carry"}, {7'd0, bus.CARRY_OUT}, {7'd0, model_carry(exp_out)});
    endtask

    task automatic idle();
        bus.ADH_LOAD = 1'b0;
        bus.PCH_LOAD = 1'b0;
        bus.INC      = 1'b0;
        bus.CARRY_IN = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle();
        bus.ADH_DATA = 8'h00;
        bus.PCH_DATA = 8'h00;

        // Reset held with an ADH load pending
        rst_n        = 1'b0;
        bus.ADH_DATA = 8'hAA;
        bus.ADH_LOAD = 1'b1;
        exp_out      = 0;
        #2;
        check("reset_immediate", bus.OUT, 8'h00);
        check("reset_carry", {7'd0, bus.CARRY_OUT}, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", bus.OUT, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step("reset_release_load");
        check("reset_release_aa", bus.OUT, 8'hAA);
        idle();

        // Data without strobe must not reach OUT
        bus.ADH_DATA = 8'h3C;
        bus.PCH_DATA = 8'hC3;
        step("no_strobe_1");
        step("no_strobe_2");
        check("no_strobe_aa", bus.OUT, 8'hAA);

        bus.ADH_DATA = 8'h5A;
        bus.ADH_LOAD = 1'b1;
        step("adh_pulse");
        idle();
        step("adh_hold");
        check("adh_5a", bus.OUT, 8'h5A);

        bus.PCH_DATA = 8'h5B;
        step("pch_before");
        check("pch_before_5a", bus.OUT, 8'h5A);
        bus.PCH_LOAD = 1'b1;
        step("pch_pulse");
        idle();
        check("pch_5b", bus.OUT, 8'h5B);

        bus.ADH_DATA = 8'h12;
        bus.PCH_DATA = 8'h34;
        bus.ADH_LOAD = 1'b1;
        bus.PCH_LOAD = 1'b1;
        step("priority");
        idle();
        check("priority_12", bus.OUT, 8'h12);

        // Strobe held: OUT follows the source one cycle behind
        bus.PCH_LOAD = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.PCH_DATA = 8'(8'hF0 + i * 5);
            step("pch_held");
        end
        bus.PCH_DATA = 8'hFF;
        step("load_ff");
        check("load_ff_verbatim", bus.OUT, 8'hFF);
        idle();

        // Async reset in the middle of a pending load
        bus.ADH_DATA = 8'h55;
        bus.ADH_LOAD = 1'b1;
        step("load_55");
        idle();
        bus.PCH_DATA = 8'h77;
        bus.PCH_LOAD = 1'b1;
        @(negedge clk);
        #2;
        rst_n   = 1'b0;
        exp_out = 0;
        #1;
        check("midload_reset", bus.OUT, 8'h00);
        @(posedge clk);
        #1;
        check("midload_reset_edge", bus.OUT, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        step("after_reset");
        check("after_reset_00", bus.OUT, 8'h00);

        // Increment across the page boundary
        bus.ADH_DATA = 8'hFE;
        bus.ADH_LOAD = 1'b1;
        step("load_fe");
        idle();
        bus.INC      = 1'b1;
        bus.CARRY_IN = 1'b1;
        #1;
        check("carry_at_fe", {7'd0, bus.CARRY_OUT}, 8'h00);
        step("inc_1");
        check("inc_1_value", bus.OUT, INC_EN ? 8'hFF : 8'hFE);
        step("inc_2");
        check("inc_2_value", bus.OUT, INC_EN ? 8'h00 : 8'hFE);
        idle();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            bus.ADH_LOAD = ($urandom_range(0, 3) == 0);
            bus.PCH_LOAD = ($urandom_range(0, 3) == 0);
            bus.INC      = 1'($urandom_range(0, 1));
            bus.CARRY_IN = ($urandom_range(0, 2) != 0);
            bus.ADH_DATA = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            bus.PCH_DATA = ($urandom_range(0, 1) == 0) ? 8'((exp_out + 1) % 256) : 8'($urandom);
            step("random");
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_pchs.md
Name: reg_pchs

Overview:
- Program-counter-high select register (PCHS) in the 6502 address path.
- Registers the next PCH value from one of two sources: the PCH feedback/increment path (PCH_DATA) or the ADH internal bus (ADH_DATA).
- Output OUT drives the PCH increment logic and the address-high bus.
- Synchronous to the CPU clock, with asynchronous active-low reset.

Parameters:
- WIDTH, 8, data width of PCH, ADH and OUT.
- RESET_VALUE, 8'h00, value of OUT while reset is asserted and after release.

Ports:
- CLK  input  1  CPU clock; all state changes on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- PCH_LOAD  input  1  load PCH_DATA into the register on the next CLK rising edge.
- ADH_LOAD  input  1  load ADH_DATA into the register on the next CLK rising edge.
- PCH_DATA  input  WIDTH  PCH feedback value, typically OUT+1 from the incrementer.
- ADH_DATA  input  WIDTH  value from the ADH internal bus.
- INC  input  1  internal increment request (only used with PCHS_INC_EN).
- CARRY_IN  input  1  carry from PCL incrementer (only used with PCHS_INC_EN).
- CARRY_OUT  output  1  carry out of PCH increment (only used with PCHS_INC_EN).
- OUT  output  WIDTH  registered PCH value.

Behaviour:
- Clock and reset (already decided): one clock, CLK; reset RST_N is asynchronous and active-low.
- RST_N low: OUT = RESET_VALUE immediately, independent of CLK. CARRY_OUT = 0.
- RST_N high: OUT updates only on the CLK rising edge. Priority, highest first:
  1) ADH_LOAD=1: OUT <= ADH_DATA.
  2) PCH_LOAD=1: OUT <= PCH_DATA.
  3) PCHS_INC_EN defined and INC=1 and CARRY_IN=1: OUT <= OUT+1, modulo 2^WIDTH.
  4) Otherwise: OUT holds its value.
- Simultaneous ADH_LOAD and PCH_LOAD: ADH wins; PCH_DATA is ignored.
- Latency: one cycle from a load strobe sampled high to the new value on OUT.
- Load strobe held high for N cycles: reloads every cycle; OUT follows the selected source with one-cycle delay.
- Data changes with no strobe high: never affect OUT.
- Reset asserted mid-cycle, including during an active load: OUT = RESET_VALUE at once; the pending load is discarded.
- Reset release: first load is honoured on the first rising edge where RST_N is high.
- OUT and CARRY_OUT are glitch-free registered or combinational-from-registered signals. There is no combinational path from any data input to OUT.
- Wrap-around: a load of any value, including 8'hFF, is stored verbatim. PCH_DATA = OUT+1 with OUT = 8'hFF is computed externally as 8'h00.

Optional Feature:
- Macro: PCHS_INC_EN.
- Defined:
  - Internal incrementer active per priority rule 3.
  - CARRY_OUT is combinational = INC & CARRY_IN & (OUT == all-ones); it signals a page wrap for 16-bit PC overflow.
  - At OUT = 8'hFF, an increment gives OUT = 8'h00.
- Not defined:
  - INC and CARRY_IN ignored; CARRY_OUT tied to 0.
  - Register updates only via loads or reset.

Test Plan:
- Reset: RST_N=0 with ADH_DATA=8'hAA, ADH_LOAD=1 -> OUT=8'h00 immediately and stays 8'h00 across edges; release RST_N -> next edge OUT=8'hAA.
- ADH load: ADH_DATA=8'hAA with no strobe -> OUT unchanged (8'h00); pulse ADH_LOAD for one cycle -> OUT=8'hAA after that edge and holds.
- PCH load: with OUT=8'hAA, set PCH_DATA=OUT+1=8'hAB -> OUT still 8'hAA; pulse PCH_LOAD -> OUT=8'hAB.
- Priority: ADH_DATA=8'h12, PCH_DATA=8'h34, both strobes high for one cycle -> OUT=8'h12.
- Async reset mid-load: OUT=8'h55, PCH_LOAD=1, PCH_DATA=8'h77, RST_N pulsed low between edges -> OUT=8'h00 at once, not 8'h77.
- PCHS_INC_EN build: OUT=8'hFE, INC=1, CARRY_IN=1 for 2 cycles -> 8'hFF then 8'h00; CARRY_OUT=1 while OUT=8'hFF. Same stimulus without macro -> OUT holds 8'hFE, CARRY_OUT=0.
